// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with combinational
// coordinate decodes and hs/vs delayed to match the renderer colour pipeline.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       h_wrap;
  logic       hs_raw;
  logic       vs_raw;

  always_comb begin
    h_wrap = (hc_q == H_LAST);
    hc_d   = h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d   = vc_q;
    if (h_wrap) begin
      vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
    end
  end

  // Reset parks the counters on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q <= H_LAST;
      vc_q <= V_LAST;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  always_comb begin
    DrawX       = hc_q;
    DrawY       = vc_q;
    blank       = (hc_q < H_VIS) && (vc_q < V_VIS);
    line_start  = (hc_q == 10'd0);
    frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);
    hs_raw      = !((hc_q >= HS_START) && (hc_q < HS_END));
    vs_raw      = !((vc_q >= VS_START) && (vc_q < VS_END));
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_dly_q, hs_dly_d;
      logic [SYNC_DELAY-1:0] vs_dly_q, vs_dly_d;
      logic [SYNC_DELAY:0]   hs_ext, vs_ext;

      // Bit 0 of each extended vector is the raw decode, the top bit is the pin.
      always_comb begin
        hs_ext   = {hs_dly_q, hs_raw};
        vs_ext   = {vs_dly_q, vs_raw};
        hs_dly_d = hs_ext[SYNC_DELAY-1:0];
        vs_dly_d = vs_ext[SYNC_DELAY-1:0];
      end

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_dly_q <= '1;
          vs_dly_q <= '1;
        end else begin
          hs_dly_q <= hs_dly_d;
          vs_dly_q <= vs_dly_d;
        end
      end

      assign hs = hs_ext[SYNC_DELAY];
      assign vs = vs_ext[SYNC_DELAY];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size geometry (delay 2 and delay 0) plus a
// reduced geometry whose whole frames fit in a short run.
module tb_vga_timing_gen;
  localparam int W = 25;

  logic clk = 1'b0;
  logic rst_a_n = 1'b1;
  logic rst_s_n = 1'b1;

  logic [9:0] x_a, y_a, x_d0, y_d0, x_s, y_s;
  logic blank_a, hs_a, vs_a, ls_a, fs_a;
  logic blank_d0, hs_d0, vs_d0, ls_d0, fs_d0;
  logic blank_s, hs_s, vs_s, ls_s, fs_s;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int t_a = -1;
  int t_s = -1;
  bit run_cmp = 1'b0;

  vga_timing_gen dut_a (
    .vga_clk(clk), .reset_n(rst_a_n), .DrawX(x_a), .DrawY(y_a), .blank(blank_a),
    .hs(hs_a), .vs(vs_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) dut_d0 (
    .vga_clk(clk), .reset_n(rst_a_n), .DrawX(x_d0), .DrawY(y_d0), .blank(blank_d0),
    .hs(hs_d0), .vs(vs_d0), .line_start(ls_d0), .frame_start(fs_d0)
  );

  vga_timing_gen #(
    .H_VISIBLE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_VISIBLE(12), .V_FP(2), .V_SYNC(3), .V_BP(4), .SYNC_DELAY(3)
  ) dut_s (
    .vga_clk(clk), .reset_n(rst_s_n), .DrawX(x_s), .DrawY(y_s), .blank(blank_s),
    .hs(hs_s), .vs(vs_s), .line_start(ls_s), .frame_start(fs_s)
  );

  // ---------------- clock / elapsed-time tracking ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) t_a <= -1;
    else          t_a <= t_a + 1;
  end

  always @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) t_s <= -1;
    else          t_s <= t_s + 1;
  end

  // ---------------- behavioural model ----------------
  // t = cycles since the first edge after reset release (negative = in reset).
  function automatic logic [W-1:0] model_vec(input int t, input int hv, input int hfp,
      input int hsw, input int hbp, input int vv, input int vfp, input int vsw,
      input int vbp, input int d);
    int ht, vt, x, y, ts, sx, sy;
    logic b, h, v, ls, fs;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    if (t < 0) begin
      x = ht - 1;
      y = vt - 1;
    end else begin
      x = t % ht;
      y = (t / ht) % vt;
    end
    b  = (t >= 0) && (x < hv) && (y < vv);
    ls = (t >= 0) && (x == 0);
    fs = ls && (y == 0);
    h  = 1'b1;
    v  = 1'b1;
    ts = t - d;
    if (ts >= 0) begin
      sx = ts % ht;
      sy = (ts / ht) % vt;
      h  = !((sx >= hv + hfp) && (sx < hv + hfp + hsw));
      v  = !((sy >= vv + vfp) && (sy < vv + vfp + vsw));
    end
    return {10'(x), 10'(y), b, h, v, ls, fs};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_vec(input string name, input int t, input logic [W-1:0] act);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s t=%0d got x=%0d y=%0d b/hs/vs/ls/fs=%b required x=%0d y=%0d b/hs/vs/ls/fs=%b",
               name, t, act[24:15], act[14:5], act[4:0], e[24:15], e[14:5], e[4:0]);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      exp_q.push_back(model_vec(t_a, 640, 16, 96, 48, 480, 10, 2, 33, 2));
      exp_q.push_back(model_vec(t_a, 640, 16, 96, 48, 480, 10, 2, 33, 0));
      exp_q.push_back(model_vec(t_s, 20, 4, 6, 5, 12, 2, 3, 4, 3));
      check_vec("cyc_a", t_a, {x_a, y_a, blank_a, hs_a, vs_a, ls_a, fs_a});
      check_vec("cyc_d0", t_a, {x_d0, y_d0, blank_d0, hs_d0, vs_d0, ls_d0, fs_d0});
      check_vec("cyc_s", t_s, {x_s, y_s, blank_s, hs_s, vs_s, ls_s, fs_s});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic check_restart_a();
    next_sample();
    check_lit("rst_a_x0", int'(x_a), 0);
    check_lit("rst_a_y0", int'(y_a), 0);
    check_lit("rst_a_blank", int'(blank_a), 1);
    check_lit("rst_a_fs", int'(fs_a), 1);
    check_lit("rst_a_ls", int'(ls_a), 1);
    check_lit("rst_d0_fs", int'(fs_d0), 1);
  endtask

  task automatic check_restart_s();
    next_sample();
    check_lit("rst_s_x0", int'(x_s), 0);
    check_lit("rst_s_y0", int'(y_s), 0);
    check_lit("rst_s_blank", int'(blank_s), 1);
    check_lit("rst_s_fs", int'(fs_s), 1);
  endtask

  // ---------------- directed sequence ----------------
  int blank_l0_a = 0, hs_low_l0_a = 0, t656_a = -1, hs_fall_a = -1, hs_fall_d0 = -1;
  int ls_t0_a = -1, ls_t1_a = -1;
  int fs_t0_s = -1, fs_t1_s = -1, ls_t0_s = -1, ls_t1_s = -1;
  int blank_f0_s = 0, vs_low_f0_s = 0, hs_low_l0_s = 0, t014_s = -1, vs_fall_s = -1;
  bit wrap_a_pend = 1'b0, wrap_s_pend = 1'b0;
  int wrap_a_seen = 0, wrap_s_seen = 0;
  bit found;

  initial begin
    #1;
    rst_a_n = 1'b0;
    rst_s_n = 1'b0;
    next_sample();
    run_cmp = 1'b1;
    repeat (9) next_sample();
    check_lit("in_rst_x", int'(x_a), 799);
    check_lit("in_rst_y", int'(y_a), 524);
    check_lit("in_rst_blank", int'(blank_a), 0);
    check_lit("in_rst_hs", int'(hs_a), 1);
    check_lit("in_rst_vs", int'(vs_a), 1);
    check_lit("in_rst_fs", int'(fs_a), 0);
    check_lit("in_rst_ls", int'(ls_a), 0);
    check_lit("in_rst_s_x", int'(x_s), 34);
    check_lit("in_rst_s_y", int'(y_s), 20);
    #1;
    rst_a_n = 1'b1;
    rst_s_n = 1'b1;
    check_restart_a();
    check_lit("first_s_fs", int'(fs_s), 1);

    for (int i = 0; i < 2400; i++) begin
      if (t_a == 1) check_lit("fs_one_clk", int'(fs_a), 0);
      if (t_a < 800) begin
        if (blank_a) blank_l0_a++;
        if (!hs_a) hs_low_l0_a++;
      end
      if (x_a == 10'd656 && t656_a < 0) t656_a = t_a;
      if (!hs_a && hs_fall_a < 0) hs_fall_a = t_a;
      if (!hs_d0 && hs_fall_d0 < 0) hs_fall_d0 = t_a;
      if (ls_a) begin
        if (ls_t0_a < 0) ls_t0_a = t_a;
        else if (ls_t1_a < 0) ls_t1_a = t_a;
      end
      if (wrap_a_pend) begin
        check_lit("wrap_a_x", int'(x_a), 0);
        check_lit("wrap_a_y", int'(y_a), 1);
        wrap_a_pend = 1'b0;
        wrap_a_seen++;
      end
      if (x_a == 10'd799 && y_a == 10'd0) wrap_a_pend = 1'b1;

      if (t_s < 735) begin
        if (blank_s) blank_f0_s++;
        if (!vs_s) vs_low_f0_s++;
      end
      if (t_s < 35 && !hs_s) hs_low_l0_s++;
      if (fs_s) begin
        if (fs_t0_s < 0) fs_t0_s = t_s;
        else if (fs_t1_s < 0) fs_t1_s = t_s;
      end
      if (ls_s) begin
        if (ls_t0_s < 0) ls_t0_s = t_s;
        else if (ls_t1_s < 0) ls_t1_s = t_s;
      end
      if (x_s == 10'd0 && y_s == 10'd14 && t014_s < 0) t014_s = t_s;
      if (!vs_s && vs_fall_s < 0) vs_fall_s = t_s;
      if (wrap_s_pend) begin
        check_lit("wrap_s_x", int'(x_s), 0);
        check_lit("wrap_s_y", int'(y_s), 0);
        wrap_s_pend = 1'b0;
        wrap_s_seen++;
      end
      if (x_s == 10'd34 && y_s == 10'd20) wrap_s_pend = 1'b1;
      next_sample();
    end

    check_lit("blank_line_a", blank_l0_a, 640);
    check_lit("hs_width_a", hs_low_l0_a, 96);
    check_lit("hs_delay_a", hs_fall_a - t656_a, 2);
    check_lit("hs_delay_d0", hs_fall_d0 - t656_a, 0);
    check_lit("line_period_a", ls_t1_a - ls_t0_a, 800);
    check_lit("wrap_a_seen", wrap_a_seen, 1);
    check_lit("frame_period_s", fs_t1_s - fs_t0_s, 735);
    check_lit("line_period_s", ls_t1_s - ls_t0_s, 35);
    check_lit("blank_frame_s", blank_f0_s, 240);
    check_lit("vs_width_s", vs_low_f0_s, 105);
    check_lit("vs_delay_s", vs_fall_s - t014_s, 3);
    check_lit("hs_width_s", hs_low_l0_s, 6);
    check_lit("wrap_s_seen", wrap_s_seen, 3);

    // mid-frame reset of the full-size pair while hs is low
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (x_a == 10'd700) found = 1'b1;
      else next_sample();
    end
    check_lit("find_a_700", int'(found), 1);
    if (found) begin
      check_lit("pre_rst_hs_a", int'(hs_a), 0);
      check_lit("pre_rst_hs_d0", int'(hs_d0), 0);
      #1;
      rst_a_n = 1'b0;
      #1;
      check_lit("async_hs_a", int'(hs_a), 1);
      check_lit("async_hs_d0", int'(hs_d0), 1);
      check_lit("async_x_a", int'(x_a), 799);
      check_lit("async_y_a", int'(y_a), 524);
      repeat (3) @(negedge clk);
      #2;
      rst_a_n = 1'b1;
      check_restart_a();
      next_sample();
      check_lit("restart_fs_drop_a", int'(fs_a), 0);
      check_lit("restart_x1_a", int'(x_a), 1);
    end
    rst_a_n = 1'b1;

    // mid-frame reset of the reduced geometry while both syncs are low
    found = 1'b0;
    for (int i = 0; i < 800 && !found; i++) begin
      if (x_s == 10'd29 && y_s == 10'd15) found = 1'b1;
      else next_sample();
    end
    check_lit("find_s_29_15", int'(found), 1);
    if (found) begin
      check_lit("pre_rst_hs_s", int'(hs_s), 0);
      check_lit("pre_rst_vs_s", int'(vs_s), 0);
      #1;
      rst_s_n = 1'b0;
      #1;
      check_lit("async_hs_s", int'(hs_s), 1);
      check_lit("async_vs_s", int'(vs_s), 1);
      check_lit("async_x_s", int'(x_s), 34);
      check_lit("async_y_s", int'(y_s), 20);
      repeat (3) @(negedge clk);
      #2;
      rst_s_n = 1'b1;
      check_restart_s();
    end
    rst_s_n = 1'b1;

    repeat (100) next_sample();
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
